// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: forms the write-back value at capture and holds it in a
// 2-entry skid buffer (main + skid) with valid/ready handshake and a retire counter.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int MEM_W  = 16,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [MEM_W-1:0]  mem_data,
    input  logic              md_sel,
    input  logic              sign_ext,
    input  logic              rw_in,
    input  logic [REG_AW-1:0] dest_in,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_rw,
    output logic [CNT_W-1:0]  retired
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] dest;
        logic              rw;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t state, state_nxt;
    entry_t main_q, skid_q, in_entry;

    logic accept, pop;
    logic load_main_in, load_main_skid, load_skid;

    // Write-back value is resolved once, at capture, so held entries never re-evaluate.
    always_comb begin
        in_entry      = '0;
        if (md_sel) begin
            if (sign_ext)
                in_entry.data = {{(DATA_W-MEM_W){mem_data[MEM_W-1]}}, mem_data};
            else
                in_entry.data = {{(DATA_W-MEM_W){1'b0}}, mem_data};
        end else begin
            in_entry.data = alu_result;
        end
        in_entry.dest = dest_in;
        in_entry.rw   = rw_in & (dest_in != '0);
    end

    assign accept = in_valid & in_ready;
    assign pop    = wb_valid & wb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !pop)      state_nxt = TWO;
                    else if (!accept && pop) state_nxt = EMPTY;
                end
                TWO:     if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs decode registered state only; wb_ready never reaches in_ready.
    always_comb begin
        in_ready       = (state != TWO);
        wb_valid       = (state != EMPTY);
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            unique case (state)
                EMPTY: load_main_in = accept;
                ONE: begin
                    load_main_in = accept & pop;
                    load_skid    = accept & ~pop;
                end
                TWO:     load_main_skid = pop;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    // Pops during a flush cycle still retire; flush never clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   retired <= '0;
        else if (pop) retired <= retired + 1'b1;
    end

    assign wb_data = main_q.data;
    assign wb_dest = main_q.dest;
    assign wb_rw   = main_q.rw;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus random traffic
// checked against a queue-based model of a 2-deep in-order buffer.
module tb_mem_wb_stage;
    localparam int DATA_W = 32, MEM_W = 16, REG_AW = 5, CNT_W = 16;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              flush = 0, in_valid = 0, md_sel = 0, sign_ext = 0, rw_in = 0, wb_ready = 0;
    logic [DATA_W-1:0] alu_result = '0;
    logic [MEM_W-1:0]  mem_data = '0;
    logic [REG_AW-1:0] dest_in = '0;
    logic              in_ready, wb_valid, wb_rw;
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] wb_dest;
    logic [CNT_W-1:0]  retired;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DATA_W), .MEM_W(MEM_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .mem_data(mem_data), .md_sel(md_sel), .sign_ext(sign_ext),
        .rw_in(rw_in), .dest_in(dest_in), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_dest(wb_dest), .wb_rw(wb_rw), .retired(retired)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] dest;
        logic              rw;
    } exp_t;

    exp_t             q[$];
    logic [CNT_W-1:0] m_ret = '0;
    int               checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t form();
        exp_t e;
        if (!md_sel)       e.data = alu_result;
        else if (sign_ext) e.data = mem_data[15] ? 32'hFFFF0000 + mem_data : {16'h0, mem_data};
        else               e.data = {16'h0, mem_data};
        e.dest = dest_in;
        e.rw   = rw_in && dest_in != 0;
        return e;
    endfunction

    // Model of one clock edge using the inputs currently driven.
    task automatic model_step();
        bit pop, acc;
        pop = q.size() > 0 && wb_ready;
        acc = in_valid && q.size() < 2;
        if (pop) m_ret = m_ret + 1'b1;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(form());
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(q.size() > 0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < 2));
        chk({tag, "_retired"}, 32'(retired), 32'(m_ret));
        if (q.size() > 0) begin
            chk({tag, "_wb_data"}, wb_data, q[0].data);
            chk({tag, "_wb_dest"}, 32'(wb_dest), 32'(q[0].dest));
            chk({tag, "_wb_rw"}, 32'(wb_rw), 32'(q[0].rw));
        end
    endtask

    task automatic tick(input string tag, input bit do_chk);
        model_step();
        @(negedge clk);
        if (do_chk) check_all(tag);
    endtask

    task automatic drive(input bit iv, input logic [31:0] alu, input logic [15:0] md, input bit msel,
                         input bit se, input bit rw, input logic [4:0] dst, input bit wbr, input bit fl);
        in_valid = iv; alu_result = alu; mem_data = md; md_sel = msel; sign_ext = se;
        rw_in = rw; dest_in = dst; wb_ready = wbr; flush = fl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        q.delete();
        m_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [CNT_W-1:0] r0;
    logic [31:0]      seen[$];
    bit               acc_now;

    initial begin
        #3;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_dest", 32'(wb_dest), 0);
        chk("rst_wb_rw", 32'(wb_rw), 0);
        chk("rst_retired", 32'(retired), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);

        // 1: sign-extended load, one-cycle latency
        drive(1, 0, 16'h8002, 1, 1, 1, 3, 1, 0);
        tick("t1", 1);
        chk("t1_valid", 32'(wb_valid), 1);
        chk("t1_data", wb_data, 32'hFFFF8002);
        chk("t1_dest", 32'(wb_dest), 3);
        chk("t1_rw", 32'(wb_rw), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("t1b", 1);
        chk("t1_retired", 32'(retired), 1);

        // 2: zero-extended load, then ALU result
        drive(1, 0, 16'h8002, 1, 0, 1, 4, 1, 0);
        tick("t2a", 1);
        chk("t2_zext", wb_data, 32'h00008002);
        drive(1, 9, 16'hFFFF, 0, 1, 1, 5, 1, 0);
        tick("t2b", 1);
        chk("t2_alu", wb_data, 9);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("t2c", 1);

        // 3: back-pressure with three back-to-back offers
        r0 = retired;
        drive(1, 4, 0, 0, 0, 1, 6, 0, 0); tick("t3a", 1);
        drive(1, 5, 0, 0, 0, 1, 6, 0, 0); tick("t3b", 1);
        chk("t3_in_ready_low", 32'(in_ready), 0);
        drive(1, 7, 0, 0, 0, 1, 6, 0, 0); tick("t3c", 1);
        wb_ready = 1;
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            if (wb_valid) seen.push_back(wb_data);
            acc_now = in_valid && in_ready;
            tick("t3d", 1);
            if (acc_now) in_valid = 0;
            if (!wb_valid && !in_valid) break;
        end
        chk("t3_count", seen.size(), 3);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] want;
            want = (i == 0) ? 4 : (i == 1) ? 5 : 7;
            chk($sformatf("t3_seq%0d", i), (i < seen.size()) ? seen[i] : 32'hDEAD, want);
        end
        chk("t3_retired", 32'(retired - r0), 3);

        // 4: write to r0 flows but is suppressed
        r0 = retired;
        drive(1, 2, 0, 0, 0, 1, 0, 1, 0); tick("t4a", 1);
        chk("t4_valid", 32'(wb_valid), 1);
        chk("t4_rw", 32'(wb_rw), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick("t4b", 1);
        chk("t4_retired", 32'(retired - r0), 1);

        // 5: flush in TWO with a same-cycle pop
        drive(1, 4, 0, 0, 0, 1, 1, 0, 0); tick("t5a", 1);
        drive(1, 5, 0, 0, 0, 1, 2, 0, 0); tick("t5b", 1);
        r0 = retired;
        drive(1, 6, 0, 0, 0, 1, 2, 1, 1); tick("t5c", 1);
        chk("t5_valid", 32'(wb_valid), 0);
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_retired", 32'(retired - r0), 1);
        // flush while accepting in EMPTY discards the entry
        drive(1, 8, 0, 0, 0, 1, 2, 1, 1); tick("t5d", 1);
        chk("t5_discard", 32'(wb_valid), 0);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            drive($urandom_range(0, 1), $urandom, 16'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
            tick("rnd", 1);
        end

        // 6b: async reset in TWO, checked before any clock edge
        drive(1, 11, 0, 0, 0, 1, 7, 0, 0); tick("t6a", 1);
        drive(1, 12, 0, 0, 0, 1, 7, 0, 0); tick("t6b", 1);
        chk("t6_in_two", 32'(wb_valid && !in_ready), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_valid", 32'(wb_valid), 0);
        chk("t6_arst_data", wb_data, 0);
        chk("t6_arst_dest", 32'(wb_dest), 0);
        chk("t6_arst_rw", 32'(wb_rw), 0);
        chk("t6_arst_retired", 32'(retired), 0);
        do_reset();
        check_all("t6_post");

        // 6a: counter wrap
        drive(1, 1, 0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 65535; i++) tick("wrap", 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("wrap_drain", 0);
        chk("t6_retired_max", 32'(retired), 32'hFFFF);
        drive(1, 1, 0, 0, 0, 1, 1, 1, 0); tick("wrap_fill", 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick("wrap_pop", 1);
        chk("t6_retired_wrap", 32'(retired), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
